// File: rtl/tl_host_arb.sv
// Round-robin arbiter sharing one device port among NHost crossbar hosts.
// Responses are steered back in order via a small outstanding-ID FIFO.
module tl_host_arb #(
    parameter int NHost          = 3,
    parameter int MaxOutstanding = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NHost-1:0]      h_a_valid_i,
    output logic [NHost-1:0]      h_a_ready_o,
    input  logic [NHost*32-1:0]   h_a_addr_i,
    input  logic [NHost-1:0]      h_a_we_i,
    input  logic [NHost*32-1:0]   h_a_wdata_i,
    output logic [NHost-1:0]      h_d_valid_o,
    input  logic [NHost-1:0]      h_d_ready_i,
    output logic [31:0]           h_d_rdata_o,
    output logic                  h_d_error_o,
    output logic                  d_a_valid_o,
    output logic [31:0]           d_a_addr_o,
    output logic                  d_a_we_o,
    output logic [31:0]           d_a_wdata_o,
    input  logic                  d_a_ready_i,
    input  logic                  d_d_valid_i,
    input  logic [31:0]           d_d_rdata_i,
    input  logic                  d_d_error_i,
    output logic                  d_d_ready_o,
    output logic [NHost-1:0]      grant_o,
    output logic                  unexp_rsp_o
);
    localparam int IW = (NHost > 1) ? $clog2(NHost) : 1;
    localparam int PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CW = $clog2(MaxOutstanding + 1);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IW-1:0]     r_rr_ptr;
    logic [IW-1:0]     r_win;
    logic [31:0]       r_addr;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic [IW-1:0]     r_fifo [MaxOutstanding];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_unexp;

    logic              w_found;
    logic [IW-1:0]     w_sel;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [IW-1:0]     w_head;

    function automatic logic [IW-1:0] f_wrap(input int v);
        return IW'(v % NHost);
    endfunction

    function automatic logic [PW-1:0] f_pinc(input logic [PW-1:0] p);
        return (p == PW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    // Walk the search order backwards so the host nearest rr_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = NHost - 1; i >= 0; i--) begin
            if (h_a_valid_i[f_wrap(int'(r_rr_ptr) + i)]) begin
                w_found = 1'b1;
                w_sel   = f_wrap(int'(r_rr_ptr) + i);
            end
        end
    end

    assign w_full   = (r_count == CW'(MaxOutstanding));
    assign w_empty  = (r_count == '0);
    // Holding off accepts in reset keeps every host-facing output quiet.
    assign w_accept = rst_ni && (r_state == S_IDLE) && w_found && !w_full;
    assign w_head   = r_fifo[r_rptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        h_a_ready_o = '0;
        w_push      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    h_a_ready_o[w_sel] = 1'b1;
                    w_state_nxt        = S_SEND;
                end
            end
            S_SEND: begin
                if (d_a_ready_i) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        grant_o = '0;
        if (r_state == S_SEND) grant_o[r_win] = 1'b1;
    end

    // An empty FIFO means nobody asked: swallow the beat.
    always_comb begin
        h_d_valid_o = '0;
        d_d_ready_o = d_d_valid_i;
        w_pop       = 1'b0;
        if (!w_empty) begin
            h_d_valid_o[w_head] = d_d_valid_i;
            d_d_ready_o         = h_d_ready_i[w_head];
            w_pop               = d_d_valid_i & h_d_ready_i[w_head];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= '0;
            r_win    <= '0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_unexp  <= 1'b0;
            for (int i = 0; i < MaxOutstanding; i++) r_fifo[i] <= '0;
        end else begin
            if (w_accept) begin
                r_win   <= w_sel;
                r_addr  <= h_a_addr_i[32*int'(w_sel) +: 32];
                r_we    <= h_a_we_i[w_sel];
                r_wdata <= h_a_wdata_i[32*int'(w_sel) +: 32];
            end
            if (w_push) begin
                r_fifo[r_wptr] <= r_win;
                r_wptr         <= f_pinc(r_wptr);
                r_rr_ptr       <= (r_win == IW'(NHost - 1)) ? '0 : r_win + 1'b1;
            end
            if (w_pop) r_rptr <= f_pinc(r_rptr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_empty && d_d_valid_i) r_unexp <= 1'b1;
        end
    end

    assign d_a_valid_o = (r_state == S_SEND);
    assign d_a_addr_o  = r_addr;
    assign d_a_we_o    = r_we;
    assign d_a_wdata_o = r_wdata;
    assign h_d_rdata_o = d_d_rdata_i;
    assign h_d_error_o = d_d_error_i;
    assign unexp_rsp_o = r_unexp;
endmodule
